// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with flush-to-zero and all five rounding modes.
// Optional macro FP_MUL_EXC_EN adds the invalid/inexact exception outputs.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   r_mode,
    input  logic [W-1:0] fp_X,
    input  logic [W-1:0] fp_Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] fp_Z,
    output logic         ovrf,
    output logic         udrf
`ifdef FP_MUL_EXC_EN
    ,
    output logic         invalid,
    output logic         inexact
`endif
);

    localparam int EW = EXP_W + 2;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
    // moves in lockstep on advance; a stalled output keeps every stage frozen.
    logic advance;
    logic s3_valid;

    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;

    logic [EXP_W-1:0] x_exp, y_exp;
    logic [MAN_W-1:0] x_frac, y_frac;
    logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    cls_t             in_cls;

    assign x_exp  = fp_X[W-2:MAN_W];
    assign y_exp  = fp_Y[W-2:MAN_W];
    assign x_frac = fp_X[MAN_W-1:0];
    assign y_frac = fp_Y[MAN_W-1:0];

    // Exponent zero covers subnormals, which are treated as signed zero.
    always_comb begin
        x_zero = (x_exp == '0);
        y_zero = (y_exp == '0);
        x_inf  = (&x_exp) && (x_frac == '0);
        y_inf  = (&y_exp) && (y_frac == '0);
        x_nan  = (&x_exp) && (x_frac != '0);
        y_nan  = (&y_exp) && (y_frac != '0);
        in_cls = CLS_NORM;
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
            in_cls = CLS_NAN;
        else if (x_inf || y_inf)
            in_cls = CLS_INF;
        else if (x_zero || y_zero)
            in_cls = CLS_ZERO;
    end

    logic             s1_valid, s1_sign;
    cls_t             s1_cls;
    logic [EXP_W-1:0] s1_ex, s1_ey;
    logic [SW-1:0]    s1_mx, s1_my;
    logic [2:0]       s1_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= fp_X[W-1] ^ fp_Y[W-1];
            s1_cls   <= in_cls;
            s1_ex    <= x_exp;
            s1_ey    <= y_exp;
            s1_mx    <= {1'b1, x_frac};
            s1_my    <= {1'b1, y_frac};
            s1_mode  <= r_mode;
        end
    end

    logic          s2_valid, s2_sign;
    cls_t          s2_cls;
    logic [EW-1:0] s2_exp;
    logic [PW-1:0] s2_prod;
    logic [2:0]    s2_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_exp   <= {2'b00, s1_ex} + {2'b00, s1_ey} - BIAS;
            s2_prod  <= PW'(s1_mx) * PW'(s1_my);
            s2_mode  <= s1_mode;
        end
    end

    logic [PW-1:0]  norm;
    logic [SW-1:0]  mant;
    logic           guard, sticky, inc, udf, ovf, to_inf;
    logic [EW-1:0]  exp_n, exp_r;
    logic [SW:0]    mant_r;
    logic [MAN_W-1:0] frac_r;
    logic [W-1:0]   z_n;
    logic           ovrf_n, udrf_n;

    // Product lies in [1,4): a set top bit means one extra exponent step.
    always_comb begin
        norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
        mant   = norm[PW-1:MAN_W+1];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        exp_n  = s2_exp + {{(EW-1){1'b0}}, s2_prod[PW-1]};
        udf    = exp_n[EW-1] || (exp_n == '0);

        case (s2_mode)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s2_sign & (guard | sticky);
            3'b011:  inc = !s2_sign & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = guard & (sticky | mant[0]);
        endcase

        mant_r = {1'b0, mant} + {{SW{1'b0}}, inc};
        if (mant_r[SW]) begin
            exp_r  = exp_n + EW'(1);
            frac_r = mant_r[MAN_W:1];
        end else begin
            exp_r  = exp_n;
            frac_r = mant_r[MAN_W-1:0];
        end
        ovf = !udf && (exp_r >= EMAX);

        case (s2_mode)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = s2_sign;
            3'b011:  to_inf = !s2_sign;
            default: to_inf = 1'b1;
        endcase

        z_n    = '0;
        ovrf_n = 1'b0;
        udrf_n = 1'b0;
        case (s2_cls)
            CLS_NAN:  z_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            CLS_INF:  z_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: z_n = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (udf) begin
                    z_n    = {s2_sign, {(W-1){1'b0}}};
                    udrf_n = 1'b1;
                end else if (ovf) begin
                    ovrf_n = 1'b1;
                    z_n    = to_inf ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                    : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                end else begin
                    z_n = {s2_sign, exp_r[EXP_W-1:0], frac_r};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            fp_Z     <= '0;
            ovrf     <= 1'b0;
            udrf     <= 1'b0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            fp_Z     <= z_n;
            ovrf     <= ovrf_n;
            udrf     <= udrf_n;
        end
    end

`ifdef FP_MUL_EXC_EN
    logic inv_n, inx_n;

    // Any flushed normal product is nonzero, so underflow is always inexact.
    always_comb begin
        inv_n = (s2_cls == CLS_NAN);
        inx_n = 1'b0;
        if (s2_cls == CLS_NORM)
            inx_n = udf || ovf || guard || sticky;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else if (advance) begin
            invalid <= inv_n;
            inexact <= inx_n;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: scoreboard queue filled at acceptance, drained by an output monitor,
// with random operands checked against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int QW    = W + 4;
    localparam int EONES = (1 << EXP_W) - 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   r_mode = 3'd0;
    logic [W-1:0] fp_X = '0;
    logic [W-1:0] fp_Y = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] fp_Z;
    logic         ovrf, udrf;
    logic         dut_inv, dut_inx;

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_mode    (r_mode),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf)
`ifdef FP_MUL_EXC_EN
        ,
        .invalid   (dut_inv),
        .inexact   (dut_inx)
`endif
    );

`ifndef FP_MUL_EXC_EN
    assign dut_inv = 1'b0;
    assign dut_inx = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [QW-1:0] exp_q[$];
    int accept_cnt = 0;
    int acc_cyc = 0;
    logic bp_en = 1'b0;
    logic or_force = 1'b1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %0s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic logic [QW-1:0] mk(input logic [W-1:0] z, input logic ov, input logic ud,
                                         input logic iv, input logic ix);
        return {z, ov, ud, iv, ix};
    endfunction

    // ---------------- reference model ----------------
    // Works on the exact integer product and decides rounding by comparing the
    // discarded remainder with one half ulp.
    function automatic logic [QW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [2:0] m);
        int ex, ey, e, k, sh;
        longint fx, fy, p, q, rem, half;
        logic s, xz, yz, xi, yi, xn, yn, inc, to_inf;
        logic [W-1:0] z;
        ex = int'(x[W-2:MAN_W]);
        ey = int'(y[W-2:MAN_W]);
        fx = longint'(x[MAN_W-1:0]);
        fy = longint'(y[MAN_W-1:0]);
        s  = x[W-1] ^ y[W-1];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == EONES) && (fx == 0);
        yi = (ey == EONES) && (fy == 0);
        xn = (ex == EONES) && (fx != 0);
        yn = (ey == EONES) && (fy != 0);
        if (xn || yn || (xi && yz) || (yi && xz))
            return mk({1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}, 1'b0, 1'b0, 1'b1, 1'b0);
        if (xi || yi)
            return mk({s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}, 1'b0, 1'b0, 1'b0, 1'b0);
        if (xz || yz)
            return mk({s, {(W-1){1'b0}}}, 1'b0, 1'b0, 1'b0, 1'b0);
        p = ((longint'(1) << MAN_W) + fx) * ((longint'(1) << MAN_W) + fy);
        k = (p >= (longint'(1) << (2 * MAN_W + 1))) ? 2 * MAN_W + 1 : 2 * MAN_W;
        e = ex + ey - BIAS + (k - 2 * MAN_W);
        if (e < 1)
            return mk({s, {(W-1){1'b0}}}, 1'b0, 1'b1, 1'b0, 1'b1);
        sh   = k - MAN_W;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && (rem != 0);
            3'd3:    inc = !s && (rem != 0);
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && q[0]);
        endcase
        if (inc) q = q + 1;
        if (q == (longint'(1) << (MAN_W + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= EONES) begin
            case (m)
                3'd1:    to_inf = 1'b0;
                3'd2:    to_inf = s;
                3'd3:    to_inf = !s;
                default: to_inf = 1'b1;
            endcase
            z = to_inf ? {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            return mk(z, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        z = {s, e[EXP_W-1:0], q[MAN_W-1:0]};
        return mk(z, 1'b0, 1'b0, 1'b0, rem != 0);
    endfunction

    function automatic logic [W-1:0] rand_fp();
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        int c;
        c = $urandom_range(0, 15);
        f = MAN_W'($urandom);
        if (c == 0)      e = '0;
        else if (c == 1) begin e = '1; if ($urandom_range(0, 1) == 0) f = '0; end
        else if (c < 4)  e = EXP_W'($urandom_range(1, 30));
        else if (c < 6)  e = EXP_W'($urandom_range(220, 254));
        else             e = EXP_W'($urandom_range(90, 165));
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge that took the operands.
    task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] m,
                            input logic [QW-1:0] want);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        fp_X = x;
        fp_Y = y;
        r_mode = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(want);
                accept_cnt++;
                acc_cyc = cyc;
                done = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] m);
        send_exp(x, y, m, ref_mul(x, y, m));
    endtask

    // Cycles from the cycle the operands were taken to the first cycle out_valid is seen.
    task automatic measure_latency(input string name);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk(name, 64'(cyc - acc_cyc), 64'd3);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = bp_en ? ($urandom_range(0, 3) != 0) : or_force;
    end

    // ---------------- monitor / scoreboard ----------------
    logic          stalled = 1'b0;
    logic [QW-1:0] held;
    logic [QW-1:0] got_v, want_v;

    always @(negedge clk) begin
        got_v = {fp_Z, ovrf, udrf, dut_inv, dut_inx};
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) chk("stall_hold", {1'b0, out_valid, got_v}, {1'b0, 1'b1, held});
            if (out_valid && out_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(got_v), 64'd0);
                end else begin
                    want_v = exp_q.pop_front();
`ifndef FP_MUL_EXC_EN
                    want_v[1:0] = 2'b00;
`endif
                    chk("result", 64'(got_v), 64'(want_v));
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                held = got_v;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int base;
    bit six_done;

    initial begin
        // Operands held valid during reset must be discarded.
        in_valid = 1'b1;
        fp_X = 32'h3F800000;
        fp_Y = 32'h40000000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_fp_Z", 64'(fp_Z), 64'd0);
        chk("reset_flags", {62'd0, ovrf, udrf}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        chk("no_output_after_reset", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Directed values with the golden numbers written out.
        send_exp(32'h3FC00000, 32'h40000000, 3'd0, mk(32'h40400000, 0, 0, 0, 0));
        measure_latency("latency_basic");
        @(posedge clk);
        #1;
        send_exp(32'h7F000000, 32'h7F000000, 3'd0, mk(32'h7F800000, 1, 0, 0, 1));
        send_exp(32'h7F000000, 32'h7F000000, 3'd1, mk(32'h7F7FFFFF, 1, 0, 0, 1));
        send_exp(32'hFF000000, 32'h7F000000, 3'd3, mk(32'hFF7FFFFF, 1, 0, 0, 1));
        send_exp(32'hFF000000, 32'h7F000000, 3'd2, mk(32'hFF800000, 1, 0, 0, 1));
        send_exp(32'h00800000, 32'h00800000, 3'd0, mk(32'h00000000, 0, 1, 0, 1));
        send_exp(32'h7F800000, 32'h00000000, 3'd0, mk(32'h7FC00000, 0, 0, 1, 0));
        send_exp(32'hFFC12345, 32'h3F800000, 3'd2, mk(32'h7FC00000, 0, 0, 1, 0));
        send_exp(32'hFF800000, 32'h40000000, 3'd0, mk(32'hFF800000, 0, 0, 0, 0));
        send_exp(32'h80000000, 32'h3F800000, 3'd0, mk(32'h80000000, 0, 0, 0, 0));
        send_exp(32'h00000001, 32'hBF800000, 3'd0, mk(32'h80000000, 0, 0, 0, 0));
        send_exp(32'h3F800001, 32'h3FC00000, 3'd0, mk(32'h3FC00002, 0, 0, 0, 1));
        send_exp(32'h3F800001, 32'h3FC00000, 3'd1, mk(32'h3FC00001, 0, 0, 0, 1));
        send_exp(32'h3F800003, 32'h3FC00000, 3'd7, mk(32'h3FC00004, 0, 0, 0, 1));
        send_exp(32'h3F800003, 32'h3FC00000, 3'd4, mk(32'h3FC00005, 0, 0, 0, 1));
        send_exp(32'h3FB504F3, 32'h3FB504F3, 3'd0, mk(32'h3FFFFFFF, 0, 0, 0, 1));
        send_exp(32'h3FB504F3, 32'h3FB504F3, 3'd3, mk(32'h40000000, 0, 0, 0, 1));
        drain();

        // Six back-to-back sets against a five-cycle stall.
        base = accept_cnt;
        six_done = 1'b0;
        or_force = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_fp(), rand_fp(), 3'($urandom_range(0, 7)));
                six_done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_accept_count", 64'(accept_cnt - base), 64'd3);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        or_force = 1'b1;
        for (int t = 0; t < 100 && !six_done; t++) @(posedge clk);
        chk("stream_done", 64'(six_done), 64'd1);
        #1;
        drain();

        // Reset with three results in flight: none may ever appear.
        or_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(rand_fp(), rand_fp(), 3'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        or_force = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_exp(32'h3FC00000, 32'h40000000, 3'd0, mk(32'h40400000, 0, 0, 0, 0));
        measure_latency("latency_after_flush");
        @(posedge clk);
        #1;
        drain();

        // Random operands, gaps and backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(rand_fp(), rand_fp(), 3'($urandom_range(0, 7)));
        end
        bp_en = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL provide parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL provide parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 The block SHALL provide the following ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block accepts operands this cycle
- r_mode  in  3  rounding mode
- fp_X  in  W  operand X
- fp_Y  in  W  operand Y
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fp_Z  out  W  product
- ovrf  out  1  overflow flag
- udrf  out  1  underflow flag

Function
REQ-005 r_mode encoding SHALL be 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; codes 101-111 SHALL behave as RNE.
REQ-006 The datapath SHALL be a 3-stage pipeline: S1 unpack/classify, S2 significand multiply and exponent add, S3 normalise/round/pack.
REQ-007 advance = !S3_valid || out_ready; in_ready SHALL equal advance; all stages SHALL shift together only when advance is 1.
REQ-008 An operand set SHALL be accepted when in_valid && in_ready; with out_ready held high, out_valid SHALL rise exactly 3 cycles after acceptance, with throughput 1 result per cycle.
REQ-009 While out_valid && !out_ready, fp_Z, ovrf, udrf and out_valid SHALL hold stable; no result SHALL be dropped, duplicated or reordered.
REQ-010 Bubbles (invalid slots) SHALL propagate as out_valid=0; r_mode SHALL be captured with its operands at acceptance.
REQ-011 Sign of the result SHALL be sign(X) XOR sign(Y) for all non-NaN results.
REQ-012 Subnormal inputs SHALL be treated as signed zero.
REQ-013 Any NaN operand, or inf x zero, SHALL produce canonical qNaN: sign 0, exponent all ones, fraction MSB 1, other bits 0; ovrf=udrf=0.
REQ-014 inf x finite-nonzero SHALL produce signed infinity with ovrf=0; zero x finite SHALL produce signed zero with udrf=0.
REQ-015 Rounding SHALL use the guard bit and sticky OR of all discarded product bits; a rounding carry out of the significand SHALL renormalise and increment the exponent.
REQ-016 If the rounded biased exponent >= 2^EXP_W-1, ovrf=1 and fp_Z SHALL be: RNE/RMM infinity; RTZ max finite; RDN max finite if positive, -infinity if negative; RUP +infinity if positive, max finite if negative.
REQ-017 If the biased exponent before rounding < 1, fp_Z SHALL be signed zero and udrf=1 (flush-to-zero, all modes).
REQ-018 Exponent arithmetic SHALL use EXP_W+2 bit signed width so that no intermediate wraps.

Reset
REQ-019 While rst_n=0 at a clock edge, all stage valid bits SHALL clear; out_valid=0, fp_Z=0, ovrf=0, udrf=0 on the following cycle.
REQ-020 in_ready SHALL be 1 in the first cycle after reset release; operands presented during reset SHALL be discarded.
REQ-021 Reset asserted mid-operation SHALL flush all in-flight results without emitting them.

Configuration
REQ-022 With macro FP_MUL_EXC_EN defined, the block SHALL add outputs invalid (1 bit, set for REQ-013 cases) and inexact (1 bit, set when guard|sticky=1, on overflow, or on nonzero flushed underflow), pipelined and held with fp_Z, reset to 0.
REQ-023 Without FP_MUL_EXC_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 Defaults, RNE: fp_X=0x3FC00000, fp_Y=0x40000000 -> fp_Z=0x40400000, ovrf=0, udrf=0, out_valid 3 cycles after accept.
REQ-025 fp_X=fp_Y=0x7F000000: RNE -> 0x7F800000, ovrf=1; RTZ -> 0x7F7FFFFF, ovrf=1; X=0xFF000000 with RUP -> 0xFF7FFFFF.
REQ-026 fp_X=fp_Y=0x00800000, RNE -> fp_Z=0x00000000, udrf=1; fp_X=0x7F800000, fp_Y=0x00000000 -> fp_Z=0x7FC00000 (invalid=1 when FP_MUL_EXC_EN).
REQ-027 Stream 6 back-to-back operand sets, out_ready=0 for 5 cycles -> in_ready falls after 3 accepted, all 6 results emerge in order, values stable while stalled.
REQ-028 rst_n=0 for one cycle with 3 results in flight -> out_valid=0 next cycle, none of the 3 ever emitted, next accepted input returns after 3 cycles.
